generator_fifo_wrapper: RTL and testbench
=========================================

# generator_fifo_wrapper

Test-pattern source for the AXI4-Stream datapath. An internal generator writes an incrementing counter sequence into a synchronous FIFO, and the FIFO drives an AXI4-Stream master port (m00_axis). It is used wherever a downstream stream slave needs deterministic, back-pressurable stimulus, and it is packetised with a periodic tlast.

## Interface
Parameters:
- DATA_SIZE, 32: stream data width in bits; a multiple of 8.
- FIFO_DEPTH, 16: FIFO entries; a power of 2, at least 2.
- PACKET_LEN, 8: beats per packet; tlast marks the final beat; at least 1.

Ports:
- m00_axis_aclk, in, 1: the single clock; all logic on its rising edge.
- m00_axis_aresetn, in, 1: reset. One clock; reset is synchronous and active-high. The port name is kept for bus consistency, but reset is asserted when the signal is 1.
- m00_axis_enable, in, 1: generator enable; when 1, the generator may write into the FIFO.
- m00_axis_tdata, out, DATA_SIZE: stream data, taken from the FIFO head.
- m00_axis_tstrb, out, DATA_SIZE/8: byte strobes; constant all-ones.
- m00_axis_tvalid, out, 1: asserted when the FIFO is not empty.
- m00_axis_tlast, out, 1: marks the last beat of a PACKET_LEN-beat packet.
- m00_axis_tready, in, 1: downstream ready.

## Operation
- Generator:
  - Holds gen_value, which is DATA_SIZE bits and resets to 0.
  - Write condition: wr_en = enable && !full, where full is the registered state at the start of the cycle.
  - On wr_en, gen_value is pushed and then incremented modulo 2^DATA_SIZE, so all-ones wraps to 0.
  - No value is ever skipped or dropped. While stalled, because of !enable or full, gen_value holds.
- FIFO:
  - Write pointer, read pointer and occupancy count, each log2(FIFO_DEPTH)+1 bits wide.
  - empty = (count==0); full = (count==FIFO_DEPTH).
  - rd_en = tvalid && tready.
  - Simultaneous rd_en and wr_en: count is unchanged and both pointers advance.
  - When full, a write is refused even if a read occurs in the same cycle. Its slot becomes available the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Output:
  - Show-ahead: tdata = mem[rd_ptr] whenever tvalid=1; tdata = 0 when empty.
  - tvalid = !empty.
  - Once tvalid is asserted, tdata is held stable until the handshake completes. This follows from pointer behaviour, since a read occurs only on handshake.
- Packetiser:
  - beat_cnt ranges over 0..PACKET_LEN-1 and resets to 0.
  - It increments on each handshake and wraps to 0 after PACKET_LEN-1.
  - tlast = tvalid && (beat_cnt == PACKET_LEN-1).
  - With PACKET_LEN=1, tlast = tvalid.
- Reset, including mid-operation:
  - Clears pointers, count, gen_value and beat_cnt.
  - The FIFO contents are discarded. Memory itself need not be cleared because it is masked by empty.

## Timing
- Output reset values: tvalid=0, tlast=0, tdata=0, tstrb=all-ones.
- Write-to-valid latency is 1 cycle. A write at edge N makes tvalid=1 and tdata=that value after edge N.
- First beat after reset release with enable=1: the edge after deassertion writes 0, and tvalid rises in that cycle.
- Steady state with enable=1 and tready=1: one beat per cycle, data 0,1,2,..., with tlast on values 7, 15, 23, ... for the default PACKET_LEN.
- Throughput is 1 beat/cycle and the occupancy stays at 1 in steady state.
- tready=0 with enable=1:
  - The FIFO fills to FIFO_DEPTH, which takes FIFO_DEPTH write cycles, then the generator stalls.
  - tvalid stays 1 and tdata holds the head value.
- enable=0 with tready=1: the FIFO drains one entry per cycle until empty, then tvalid=0.
- enable deasserted mid-packet: beat_cnt persists, and the packet resumes with the next beat when data flows again.
- tvalid never drops without a handshake while the FIFO is non-empty.

## Test plan
- Reset then stream:
  - Stimulus: hold reset for 3 cycles, then enable=1 and tready=1.
  - Required: the first handshaked data are 0,1,2,...,15 on consecutive cycles; tlast is high only on 7 and 15; tstrb=4'hF.
- Back-pressure fill:
  - Stimulus: enable=1 and tready=0 from reset release.
  - Required: after 16 cycles full=1 and gen_value holds at 16; tvalid=1 with tdata=0 stable.
  - Then tready=1: output is 0..15 from the FIFO, then 16, 17, ... continuous with no gap or duplicate.
- Drain:
  - Stimulus: fill 5 entries (values 0..4), then enable=0 and tready=1.
  - Required: exactly 5 beats 0..4, then tvalid=0 and tdata=0.
- Enable/ready toggling:
  - Stimulus: enable and tready both high for 3 cycles, both low for 3, high again.
  - Required: the received sequence is strictly consecutive integers; tlast occurs every 8th received beat regardless of the pauses.
- Mid-operation reset:
  - Stimulus: while the FIFO holds several entries and beat_cnt=5, assert reset for 1 cycle.
  - Required: the next cycle has tvalid=0 and tlast=0; after release, data restarts at 0 and tlast first appears on the 8th beat.
- Wrap-around:
  - Stimulus: DATA_SIZE=8; run 300 continuous beats.
  - Required: data 0..255, then 0..43; the FIFO pointers wrap with no corruption.

Source files
------------

// File: rtl/generator_fifo_wrapper.sv
// generator_fifo_wrapper: incrementing-counter test-pattern source that feeds a
// synchronous show-ahead FIFO, which drives a packetised AXI4-Stream master.
// Reset is synchronous and active-high even though the port keeps its bus name.
module generator_fifo_wrapper #(
   parameter int DATA_SIZE  = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int PACKET_LEN = 8
) (
   input  logic                     m00_axis_aclk,
   input  logic                     m00_axis_aresetn,
   input  logic                     m00_axis_enable,
   output logic [DATA_SIZE-1:0]     m00_axis_tdata,
   output logic [DATA_SIZE/8-1:0]   m00_axis_tstrb,
   output logic                     m00_axis_tvalid,
   output logic                     m00_axis_tlast,
   input  logic                     m00_axis_tready
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam int BW = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
   localparam logic [PW-1:0] DEPTH_C = PW'(FIFO_DEPTH);
   localparam logic [BW-1:0] LAST_C  = BW'(PACKET_LEN - 1);

   logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
   logic [DATA_SIZE-1:0] gen_value;
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [PW-1:0]        count;
   logic [BW-1:0]        beat_cnt;
   logic                 full;
   logic                 empty;
   logic                 wr_en;
   logic                 rd_en;
   logic                 rst;
   logic                 unused_ptr_msb;

   // Pointers run free over PW bits; only the low AW bits address memory,
   // so the wrap modulo FIFO_DEPTH is implicit.
   assign unused_ptr_msb = wr_ptr[AW] ^ rd_ptr[AW];

   assign rst   = m00_axis_aresetn;
   assign empty = (count == '0);
   assign full  = (count == DEPTH_C);
   assign wr_en = m00_axis_enable && !full;
   assign rd_en = m00_axis_tvalid && m00_axis_tready;

   // Show-ahead output: head entry visible while non-empty, zero otherwise
   always_comb begin
      m00_axis_tvalid = !empty;
      m00_axis_tdata  = empty ? '0 : mem[rd_ptr[AW-1:0]];
      m00_axis_tlast  = !empty && (beat_cnt == LAST_C);
      m00_axis_tstrb  = '1;
   end

   // Generator, FIFO bookkeeping and packet beat counter
   always_ff @(posedge m00_axis_aclk) begin
      if (rst) begin
         gen_value <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         beat_cnt  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr    <= wr_ptr + PW'(1);
            gen_value <= gen_value + DATA_SIZE'(1);
         end
         if (rd_en) begin
            rd_ptr   <= rd_ptr + PW'(1);
            beat_cnt <= (beat_cnt == LAST_C) ? '0 : beat_cnt + BW'(1);
         end
         if (wr_en && !rd_en) begin
            count <= count + PW'(1);
         end else if (rd_en && !wr_en) begin
            count <= count - PW'(1);
         end
      end
   end

   // FIFO storage; not cleared on reset because empty masks stale entries
   always_ff @(posedge m00_axis_aclk) begin
      if (wr_en && !rst) begin
         mem[wr_ptr[AW-1:0]] <= gen_value;
      end
   end

endmodule

// File: tb/tb_generator_fifo_wrapper.sv
// Directed self-checking bench for generator_fifo_wrapper: a default 32-bit
// instance and an 8-bit instance share clock and stimulus.
module tb_generator_fifo_wrapper;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        tready;

   logic [31:0] tdata;
   logic [3:0]  tstrb;
   logic        tvalid;
   logic        tlast;

   logic [7:0]  tdata8;
   logic        tstrb8;
   logic        tvalid8;
   logic        tlast8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   generator_fifo_wrapper #(.DATA_SIZE(32), .FIFO_DEPTH(16), .PACKET_LEN(8)) dut (
      .m00_axis_aclk    (clk),
      .m00_axis_aresetn (rst),
      .m00_axis_enable  (enable),
      .m00_axis_tdata   (tdata),
      .m00_axis_tstrb   (tstrb),
      .m00_axis_tvalid  (tvalid),
      .m00_axis_tlast   (tlast),
      .m00_axis_tready  (tready)
   );

   generator_fifo_wrapper #(.DATA_SIZE(8), .FIFO_DEPTH(16), .PACKET_LEN(8)) dut8 (
      .m00_axis_aclk    (clk),
      .m00_axis_aresetn (rst),
      .m00_axis_enable  (enable),
      .m00_axis_tdata   (tdata8),
      .m00_axis_tstrb   (tstrb8),
      .m00_axis_tvalid  (tvalid8),
      .m00_axis_tlast   (tlast8),
      .m00_axis_tready  (tready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; tready = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int exp_v;
      int nb;

      // Reset held 3 cycles
      rst = 1'b1; enable = 1'b0; tready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rst_tvalid", tvalid, 0);
         chk("rst_tlast", tlast, 0);
         chk("rst_tdata", tdata, 0);
         chk("rst_tstrb", tstrb, 4'hF);
         chk("rst_tvalid8", tvalid8, 0);
      end

      // Continuous stream from reset release; 8-bit instance wraps at 256
      rst = 1'b0; enable = 1'b1; tready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         tick();
         chk("str_tvalid", tvalid, 1);
         chk("str_tdata", tdata, 64'(i));
         chk("str_tlast", tlast, ((i % 8) == 7) ? 1 : 0);
         chk("wrap_tdata8", tdata8, 64'(i % 256));
         chk("wrap_tlast8", tlast8, ((i % 8) == 7) ? 1 : 0);
      end
      chk("str_tstrb", tstrb, 4'hF);
      chk("str_tstrb8", tstrb8, 1);

      // Back-pressure fill to full, then drain without gap or duplicate
      do_reset();
      enable = 1'b1; tready = 1'b0;
      for (int c = 0; c < 16; c++) tick();
      chk("bp_full", dut.full, 1);
      chk("bp_gen", dut.gen_value, 16);
      chk("bp_tvalid", tvalid, 1);
      chk("bp_tdata", tdata, 0);
      tick();
      tick();
      chk("bp_gen_hold", dut.gen_value, 16);
      chk("bp_tdata_hold", tdata, 0);
      chk("bp_tvalid_hold", tvalid, 1);
      tready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         chk("bp_drain_tvalid", tvalid, 1);
         chk("bp_drain_tdata", tdata, 64'(i));
         tick();
      end

      // Drain five entries with generator disabled
      do_reset();
      enable = 1'b1; tready = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      enable = 1'b0; tready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("dr_tvalid", tvalid, 1);
         chk("dr_tdata", tdata, 64'(i));
         chk("dr_tlast", tlast, 0);
         tick();
      end
      chk("dr_empty_tvalid", tvalid, 0);
      chk("dr_empty_tdata", tdata, 0);
      chk("dr_empty_tlast", tlast, 0);

      // Mid-operation reset: beat_cnt is 5 here, load 3 entries (5,6,7)
      enable = 1'b1; tready = 1'b0;
      for (int c = 0; c < 3; c++) tick();
      chk("mr_pre_tvalid", tvalid, 1);
      chk("mr_pre_tdata", tdata, 5);
      chk("mr_pre_beat", dut.beat_cnt, 5);
      rst = 1'b1;
      tick();
      chk("mr_tvalid", tvalid, 0);
      chk("mr_tlast", tlast, 0);
      chk("mr_tdata", tdata, 0);
      rst = 1'b0; enable = 1'b1; tready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("mr_tdata_seq", tdata, 64'(i));
         chk("mr_tlast_seq", tlast, ((i % 8) == 7) ? 1 : 0);
      end

      // Enable/ready toggling: 3 cycles on, 3 off, scoreboard on handshakes
      do_reset();
      exp_v = 0;
      nb = 0;
      for (int c = 0; c < 48; c++) begin
         enable = ((c % 6) < 3);
         tready = ((c % 6) < 3);
         if (tready && tvalid) begin
            chk("tg_tdata", tdata, 64'(exp_v));
            chk("tg_tlast", tlast, ((nb % 8) == 7) ? 1 : 0);
            exp_v++;
            nb++;
         end
         tick();
      end
      chk("tg_beats", 64'(nb), 23);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
